// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - keyboard-side PS/2 device-to-host transmitter with scan-code FIFO
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int FCW     = PW + 1;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [FCW-1:0] FULL     = FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    bit_idx, bit_idx_nx;
  logic [10:0]   frame, frame_nx;
  logic          clk_nx, data_nx, done_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  logic [7:0]    head;

  assign in_ready = (fifo_count != FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers wrap naturally since the depth is a power of two; full/empty come from the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // frame[0] is always the bit currently on the line; it shifts right as each bit completes.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    frame_nx   = frame;
    clk_nx     = 1'b1;
    data_nx    = 1'b1;
    done_nx    = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          frame_nx   = {1'b1, ~^head, head, 1'b0};
          bit_idx_nx = '0;
          state_nx   = HIGH;
          data_nx    = 1'b0;
        end
      end
      HIGH: begin
        data_nx = frame[0];
        if (cnt == DIV_LAST) begin
          cnt_nx   = '0;
          state_nx = LOW;
          clk_nx   = 1'b0;
        end
      end
      LOW: begin
        clk_nx  = 1'b0;
        data_nx = frame[0];
        if (cnt == DIV_LAST) begin
          cnt_nx = '0;
          clk_nx = 1'b1;
          if (bit_idx == 4'd10) begin
            state_nx = GAP;
            done_nx  = 1'b1;
            data_nx  = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 1'b1;
            frame_nx   = {1'b1, frame[10:1]};
            data_nx    = frame[1];
            state_nx   = HIGH;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      frame      <= 11'h7ff;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_idx_nx;
      frame      <= frame_nx;
      ps2_clk    <= clk_nx;
      ps2_data   <= data_nx;
      frame_done <= done_nx;
    end
  end

endmodule
